// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares a single-port synchronous dmem between the processor
//                port (P) and an auxiliary master port (X). Every access runs
//                IDLE -> ISSUE -> RESP so the one-cycle dmem read latency is
//                hidden behind a req/ack handshake.
//                Build option DMEM_ARB_RR_EN selects round-robin arbitration;
//                otherwise P has fixed priority with a MAX_WAIT starvation
//                guard for X.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    // processor port
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_ack,
    // auxiliary port
    input  logic              x_req,
    input  logic              x_wren,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic [DATA_W-1:0] x_rdata,
    output logic              x_ack,
    // dmem side
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // The starvation counter is 4 bits wide, so MAX_WAIT must fit in 1..15.
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_port_arbiter: MAX_WAIT must be in 1..15");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_any_req;
    logic              w_grant_x;
    logic              r_grant_x;
    logic              r_p_ack;
    logic              r_x_ack;
    logic [ADDR_W-1:0] r_dmem_address;
    logic [DATA_W-1:0] r_dmem_data;
    logic              r_dmem_wren;

    assign w_any_req = p_req | x_req;

`ifdef DMEM_ARB_RR_EN
    // Remembers which port won the most recent grant (1 = X).
    logic r_last_grant_x;

    // On a tie the port that did not win last time gets the grant.
    assign w_grant_x = x_req & (~p_req | ~r_last_grant_x);

    // Track the last winner at every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant_x <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant_x <= w_grant_x;
        end
    end
`else
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    // Number of consecutive P grants that X has lost.
    logic [3:0] r_wait_cnt;

    // P wins unless X has waited MAX_WAIT grants in a row.
    assign w_grant_x = x_req & (~p_req | (r_wait_cnt == c_max_wait));

    // Starvation counter: counts P grants against a pending X, clears otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (!x_req || w_grant_x) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != c_max_wait) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: an access always walks ISSUE then RESP back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the winner in IDLE, drive dmem in ISSUE, ack in RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant_x      <= 1'b0;
            r_p_ack        <= 1'b0;
            r_x_ack        <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_data    <= '0;
            r_dmem_wren    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_p_ack     <= 1'b0;
                    r_x_ack     <= 1'b0;
                    r_dmem_wren <= 1'b0;
                    if (w_any_req) begin
                        r_grant_x      <= w_grant_x;
                        r_dmem_address <= w_grant_x ? x_addr  : p_addr;
                        r_dmem_data    <= w_grant_x ? x_wdata : p_wdata;
                        r_dmem_wren    <= w_grant_x ? x_wren  : p_wren;
                    end
                end
                S_ISSUE: begin
                    r_dmem_wren <= 1'b0;
                    r_p_ack     <= ~r_grant_x;
                    r_x_ack     <= r_grant_x;
                end
                default: begin
                    r_dmem_wren <= 1'b0;
                    r_p_ack     <= 1'b0;
                    r_x_ack     <= 1'b0;
                end
            endcase
        end
    end

    // Read data is steered only to the acknowledged port; the other sees zero.
    assign p_rdata      = r_p_ack ? dmem_q : '0;
    assign x_rdata      = r_x_ack ? dmem_q : '0;
    assign p_ack        = r_p_ack;
    assign x_ack        = r_x_ack;
    assign dmem_address = r_dmem_address;
    assign dmem_data    = r_dmem_data;
    assign dmem_wren    = r_dmem_wren;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Self-checking bench for dmem_port_arbiter with a behavioural
//                syncram and an ack-driven scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              p_req, p_wren, x_req, x_wren;
    logic [ADDR_W-1:0] p_addr, x_addr;
    logic [DATA_W-1:0] p_wdata, x_wdata, p_rdata, x_rdata;
    logic              p_ack, x_ack;
    logic [ADDR_W-1:0] dmem_address;
    logic [DATA_W-1:0] dmem_data;
    logic              dmem_wren;
    logic [DATA_W-1:0] dmem_q;
    logic              busy;

    typedef struct packed {
        logic              is_x;
        logic              chk;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
    bit                init_done = 1'b0;
    int                n_cmp     = 0;
    int                n_fail    = 0;
    int                acks_seen = 0;
    int                wren_cnt  = 0;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack),
        .x_req(x_req), .x_wren(x_wren), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_rdata(x_rdata), .x_ack(x_ack),
        .dmem_address(dmem_address), .dmem_data(dmem_data),
        .dmem_wren(dmem_wren), .dmem_q(dmem_q), .busy(busy)
    );

    // Behavioural single-port syncram with registered read data.
    always @(posedge clock) begin
        if (!init_done) begin
            mem[12'h010] <= 32'hDEADBEEF;
            mem[12'h020] <= 32'h0BADF00D;
            init_done    <= 1'b1;
        end else if (dmem_wren) begin
            mem[dmem_address] <= dmem_data;
        end
        dmem_q <= mem[dmem_address];
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every ack and compare port and data.
    always @(negedge clock) begin
        if (!reset) begin
            if (dmem_wren) wren_cnt++;
            if (p_ack || x_ack) begin
                acks_seen++;
                check("acks_one_hot", {31'd0, p_ack & x_ack}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_port_is_x", {31'd0, x_ack}, {31'd0, e.is_x});
                    if (e.chk) check("rdata", e.is_x ? x_rdata : p_rdata, e.data);
                    check("loser_rdata", e.is_x ? p_rdata : x_rdata, 32'd0);
                end
            end
        end
    end

    // One complete access on a single port, bounded wait for its ack.
    task automatic do_access(input bit is_x, input bit wren,
                             input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        bit got;
        exp_q.push_back('{is_x: is_x, chk: ~wren, data: wren ? 32'd0 : shadow[addr]});
        if (wren) shadow[addr] = data;
        @(posedge clock); #1;
        if (is_x) begin
            x_req = 1'b1; x_wren = wren; x_addr = addr; x_wdata = data;
        end else begin
            p_req = 1'b1; p_wren = wren; p_addr = addr; p_wdata = data;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = is_x ? x_ack : p_ack;
        end
        check("ack_within_budget", {31'd0, got}, 32'd1);
        @(posedge clock); #1;
        p_req = 1'b0; x_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_busy;
        logic [3:0] exp_ack;
        int         w0;
        int         target;
        bit         done;

        for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = '0;
        shadow[12'h010] = 32'hDEADBEEF;
        shadow[12'h020] = 32'h0BADF00D;

        reset = 1'b1;
        p_req = 0; p_wren = 0; p_addr = '0; p_wdata = '0;
        x_req = 0; x_wren = 0; x_addr = '0; x_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_p_ack",     {31'd0, p_ack},     32'd0);
        check("reset_x_ack",     {31'd0, x_ack},     32'd0);
        check("reset_dmem_wren", {31'd0, dmem_wren}, 32'd0);
        check("reset_dmem_addr", {20'd0, dmem_address}, 32'd0);
        check("reset_dmem_data", dmem_data, 32'd0);
        #2 reset = 1'b0;

        // 1: single P read, cycle-accurate busy/ack profile.
        exp_q.push_back('{is_x: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
        exp_busy = 4'b0110;
        exp_ack  = 4'b0100;
        @(posedge clock); #1;
        p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h010;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                @(posedge clock); #1;
                p_req = 1'b0;
            end
            @(negedge clock);
            check("t1_busy",  {31'd0, busy},  {31'd0, exp_busy[c]});
            check("t1_p_ack", {31'd0, p_ack}, {31'd0, exp_ack[c]});
            check("t1_x_ack", {31'd0, x_ack}, 32'd0);
        end

        // 2: X write then X read of the same word.
        w0 = wren_cnt;
        do_access(1'b1, 1'b1, 12'h0FF, 32'h12345678);
        check("t2_wren_cycles_write", wren_cnt - w0, 32'd1);
        w0 = wren_cnt;
        do_access(1'b1, 1'b0, 12'h0FF, 32'h0);
        check("t2_wren_cycles_read", wren_cnt - w0, 32'd0);

        // 3: both ports held; grant pattern follows the arbitration mode.
        for (int k = 0; k < 10; k++) begin
            bit isx;
`ifdef DMEM_ARB_RR_EN
            isx = (k % 2) == 1;
`else
            isx = (k % 5) == 4;
`endif
            exp_q.push_back('{is_x: isx, chk: 1'b1,
                              data: isx ? shadow[12'h0FF] : shadow[12'h010]});
        end
        target = acks_seen + 10;
        @(posedge clock); #1;
        p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h010;
        x_req = 1'b1; x_wren = 1'b0; x_addr = 12'h0FF;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clock);
            done = (acks_seen >= target);
        end
        #1;
        p_req = 1'b0; x_req = 1'b0;
        check("t3_ten_grants", {31'd0, done}, 32'd1);

        // 4: async reset during ISSUE of a P write aborts it.
        @(posedge clock); #1;
        p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h020; p_wdata = 32'hAAAA5555;
        @(posedge clock); #1;
        check("t4_wren_in_issue", {31'd0, dmem_wren}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_busy_async",  {31'd0, busy},      32'd0);
        check("t4_wren_async",  {31'd0, dmem_wren}, 32'd0);
        check("t4_p_ack_async", {31'd0, p_ack},     32'd0);
        p_req = 1'b0; p_wren = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t4_no_ack_after_abort", {31'd0, p_ack}, 32'd0);
        end
        check("t4_mem_untouched", mem[12'h020], 32'h0BADF00D);
        do_access(1'b0, 1'b0, 12'h010, 32'h0);

        // 5: address change during ISSUE is ignored.
        exp_q.push_back('{is_x: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
        @(posedge clock); #1;
        p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h010;
        @(posedge clock); #1;
        p_addr = 12'h0FF;
        @(negedge clock);
        check("t5_addr_held", {20'd0, dmem_address}, 32'h010);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clock);
            done = p_ack;
        end
        check("t5_ack_within_budget", {31'd0, done}, 32'd1);
        @(posedge clock); #1;
        p_req = 1'b0;

        // 6: mixed traffic on both ports, including the top address.
        do_access(1'b1, 1'b1, 12'h100, 32'hA5A5A5A5);
        do_access(1'b0, 1'b1, 12'h101, 32'h5A5A5A5A);
        do_access(1'b0, 1'b0, 12'h100, 32'h0);
        do_access(1'b1, 1'b0, 12'h101, 32'h0);
        do_access(1'b0, 1'b1, 12'h100, 32'hFFFFFFFF);
        do_access(1'b1, 1'b0, 12'h100, 32'h0);
        do_access(1'b1, 1'b1, 12'hFFF, 32'h00000001);
        do_access(1'b0, 1'b0, 12'hFFF, 32'h0);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
